// File: rtl/sata_cmd_splitter.sv
// Splits one arbitrary-length sector request into stack commands of at most MAX_CHUNK sectors.
// Optional LBA range check on request acceptance: define SATA_CMD_SPLITTER_RANGE_CHECK_EN.
module sata_cmd_splitter #(
  parameter int MAX_CHUNK = 65536,
  parameter int CW        = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_type,
  input  logic [47:0] req_address,
  input  logic [47:0] req_size,
  output logic        req_ready,
  output logic        req_done,
  output logic        req_fault,
  output logic        cmd_valid,
  output logic        cmd_type,
  output logic [47:0] cmd_address,
  output logic [47:0] cmd_size,
  input  logic        cmd_ready,
  input  logic        cmd_fault,
  output logic        stat_busy,
  output logic [31:0] stat_chunks
`ifdef SATA_CMD_SPLITTER_RANGE_CHECK_EN
  ,
  input  logic        info_valid,
  input  logic [47:0] info_max_lba_address
`endif
);

  typedef enum logic [2:0] {IDLE, ISSUE, GAP, WAIT, DONE} state_t;

  localparam logic [47:0] MAX_CHUNK48 = 48'(MAX_CHUNK);

  state_t        state_q, state_d;
  logic          type_q;
  logic [47:0]   addr_q;
  logic [47:0]   rem_q;
  logic [CW-1:0] chunk_q;
  logic [CW-1:0] chunk_d;
  logic [47:0]   chunk_src;
  logic [31:0]   chunks_q;
  logic          fault_q;
  logic          accept;
  logic          xfer;
  logic          reject;

  assign accept = (state_q == IDLE) && req_valid;
  assign xfer   = (state_q == ISSUE) && cmd_ready;

`ifdef SATA_CMD_SPLITTER_RANGE_CHECK_EN
  // 49-bit compare so a request running past the top of the LBA space is rejected, not wrapped.
  logic [48:0] end_lba;
  logic [48:0] lba_limit;
  assign end_lba   = {1'b0, req_address} + {1'b0, req_size};
  assign lba_limit = {1'b0, info_max_lba_address} + 49'd1;
  assign reject    = !info_valid || (end_lba > lba_limit);
`else
  assign reject = 1'b0;
`endif

  // The first chunk comes straight from the request; later ones from what is left.
  assign chunk_src = (state_q == IDLE) ? req_size : rem_q;
  assign chunk_d   = (chunk_src >= MAX_CHUNK48) ? CW'(MAX_CHUNK) : chunk_src[CW-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    req_ready   = 1'b0;
    req_done    = 1'b0;
    req_fault   = 1'b0;
    cmd_valid   = 1'b0;
    stat_busy   = 1'b1;
    cmd_type    = type_q;
    cmd_address = addr_q;
    cmd_size    = 48'(chunk_q);
    stat_chunks = chunks_q;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        stat_busy = 1'b0;
        if (req_valid) begin
          if (reject || req_size == 48'd0) state_d = DONE;
          else                             state_d = ISSUE;
        end
      end
      ISSUE: begin
        cmd_valid = 1'b1;
        if (cmd_ready) state_d = GAP;
      end
      // One dead cycle so a cmd_ready still high from before the transfer is not mistaken for completion.
      GAP: state_d = WAIT;
      WAIT: begin
        if (cmd_ready) begin
          if (cmd_fault || rem_q == 48'd0) state_d = DONE;
          else                             state_d = ISSUE;
        end
      end
      DONE: begin
        req_done  = 1'b1;
        req_fault = fault_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      type_q   <= 1'b0;
      addr_q   <= 48'd0;
      rem_q    <= 48'd0;
      chunk_q  <= '0;
      chunks_q <= 32'd0;
      fault_q  <= 1'b0;
    end else begin
      if (accept) begin
        type_q   <= req_type;
        addr_q   <= req_address;
        rem_q    <= req_size;
        chunks_q <= 32'd0;
        fault_q  <= reject;
      end
      if (state_d == ISSUE) chunk_q <= chunk_d;
      if (xfer) begin
        addr_q <= addr_q + 48'(chunk_q);
        rem_q  <= rem_q - 48'(chunk_q);
        if (chunks_q != 32'hFFFF_FFFF) chunks_q <= chunks_q + 32'd1;
      end
      if (state_q == WAIT && cmd_ready && cmd_fault) fault_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sata_cmd_splitter.sv
// Randomised self-checking bench for sata_cmd_splitter against a behavioural stack and a chunking reference model.
module tb_sata_cmd_splitter;

  localparam int MAX_CHUNK = 65536;
  localparam int CW        = 17;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_type = 1'b0;
  logic [47:0] req_address = 48'd0;
  logic [47:0] req_size = 48'd0;
  logic        req_ready, req_done, req_fault;
  logic        cmd_valid, cmd_type;
  logic [47:0] cmd_address, cmd_size;
  logic        cmd_ready, cmd_fault;
  logic        stat_busy;
  logic [31:0] stat_chunks;
`ifdef SATA_CMD_SPLITTER_RANGE_CHECK_EN
  logic        info_valid = 1'b1;
  logic [47:0] info_max_lba_address = 48'hFFFF_FFFF_FFFF;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  sata_cmd_splitter #(.MAX_CHUNK(MAX_CHUNK), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_type(req_type), .req_address(req_address), .req_size(req_size),
    .req_ready(req_ready), .req_done(req_done), .req_fault(req_fault),
    .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_address(cmd_address), .cmd_size(cmd_size),
    .cmd_ready(cmd_ready), .cmd_fault(cmd_fault),
    .stat_busy(stat_busy), .stat_chunks(stat_chunks)
`ifdef SATA_CMD_SPLITTER_RANGE_CHECK_EN
    , .info_valid(info_valid), .info_max_lba_address(info_max_lba_address)
`endif
  );

  always #5 clk = ~clk;

  // Stack model: records each transferred command, goes busy for a random time, then completes.
  logic [47:0] rec_addr[$];
  logic [47:0] rec_size[$];
  logic        rec_type[$];
  int stk = 0, lat = 0, cmd_idx = 0, fault_at = -1;
  bit stall = 1'b0;

  initial begin
    cmd_ready = 1'b1;
    cmd_fault = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        cmd_ready = 1'b1;
        cmd_fault = 1'b0;
        stk = 0;
      end else begin
        case (stk)
          0: if (cmd_valid && cmd_ready) begin
            rec_addr.push_back(cmd_address);
            rec_size.push_back(cmd_size);
            rec_type.push_back(cmd_type);
            stk = 1;
          end
          1: begin
            cmd_ready = 1'b0;
            cmd_fault = 1'($urandom);
            lat = $urandom_range(0, 3);
            stk = 2;
          end
          default: if (!stall) begin
            if (lat == 0) begin
              cmd_ready = 1'b1;
              cmd_fault = (cmd_idx == fault_at);
              cmd_idx++;
              stk = 0;
            end else begin
              lat--;
            end
          end
        endcase
      end
    end
  end

  task automatic do_request(input logic typ, input logic [47:0] addr, input logic [47:0] size,
                            input int f_idx, input string name);
    logic [47:0] exp_addr[$];
    logic [47:0] exp_size[$];
    logic [47:0] a, rem, ch;
    logic        exp_fault, got_fault;
    logic [31:0] got_chunks;
    bit          exp_reject, seen;
    exp_reject = 1'b0;
`ifdef SATA_CMD_SPLITTER_RANGE_CHECK_EN
    exp_reject = !info_valid ||
                 (({1'b0, addr} + {1'b0, size}) > ({1'b0, info_max_lba_address} + 49'd1));
`endif
    exp_fault = exp_reject;
    a = addr;
    rem = size;
    if (!exp_reject) begin
      while (rem != 48'd0) begin
        ch = (rem > 48'(MAX_CHUNK)) ? 48'(MAX_CHUNK) : rem;
        exp_addr.push_back(a);
        exp_size.push_back(ch);
        a = a + ch;
        rem = rem - ch;
        if (exp_addr.size() - 1 == f_idx) begin
          exp_fault = 1'b1;
          break;
        end
      end
    end

    rec_addr.delete(); rec_size.delete(); rec_type.delete();
    cmd_idx = 0;
    fault_at = f_idx;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL %s idle_ready: req_ready=%b, expected 1", name, req_ready);
    end
    req_valid = 1'b1; req_type = typ; req_address = addr; req_size = size;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b0 || stat_busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL %s accept: req_ready=%b stat_busy=%b, expected 0 1", name, req_ready, stat_busy);
    end
    seen = 1'b0;
    got_fault = 1'b0;
    got_chunks = 32'd0;
    for (int cyc = 0; cyc < 400 && !seen; cyc++) begin
      if (req_done === 1'b1) begin
        seen = 1'b1;
        got_fault = req_fault;
        got_chunks = stat_chunks;
        req_valid = 1'b0;
      end else begin
        req_valid = 1'($urandom);
        req_type = 1'($urandom);
        req_address = {16'($urandom), 32'($urandom)};
        req_size = 48'($urandom_range(0, 300000));
        @(negedge clk);
      end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      req_valid = 1'b0;
      $display("[TB] FAIL %s done_timeout: no req_done within 400 cycles", name);
    end else begin
      n_checks++;
      if (got_fault !== exp_fault) begin
        n_fail++;
        $display("[TB] FAIL %s fault: req_fault=%b, expected %b", name, got_fault, exp_fault);
      end
      n_checks++;
      if (got_chunks !== 32'(exp_addr.size())) begin
        n_fail++;
        $display("[TB] FAIL %s stat_chunks: got %0d, expected %0d", name, got_chunks, exp_addr.size());
      end
    end
    @(negedge clk);
    n_checks++;
    if (req_done !== 1'b0 || req_ready !== 1'b1 || stat_busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL %s after_done: req_done=%b req_ready=%b stat_busy=%b, expected 0 1 0",
               name, req_done, req_ready, stat_busy);
    end
    n_checks++;
    if (rec_addr.size() != exp_addr.size()) begin
      n_fail++;
      $display("[TB] FAIL %s cmd_count: got %0d commands, expected %0d", name, rec_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size(); i++) begin
      if (i < rec_addr.size()) begin
        n_checks++;
        if (rec_addr[i] !== exp_addr[i] || rec_size[i] !== exp_size[i] || rec_type[i] !== typ) begin
          n_fail++;
          $display("[TB] FAIL %s cmd%0d: addr=%h size=%h type=%b, expected addr=%h size=%h type=%b",
                   name, i, rec_addr[i], rec_size[i], rec_type[i], exp_addr[i], exp_size[i], typ);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({req_ready, req_done, req_fault, cmd_valid, cmd_type, stat_busy} !== 6'b100000 ||
        cmd_address !== 48'd0 || cmd_size !== 48'd0 || stat_chunks !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_values: rdy=%b done=%b flt=%b cv=%b ct=%b busy=%b ca=%h cs=%h ch=%0d, expected 1 0 0 0 0 0 0 0 0",
               req_ready, req_done, req_fault, cmd_valid, cmd_type, stat_busy, cmd_address, cmd_size, stat_chunks);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_split();
    do_request(1'b0, 48'h100, 48'd150000, -1, "split_150000");
    do_request(1'b1, 48'h40000, 48'(3 * MAX_CHUNK), -1, "exact_multiple");
  endtask

  task automatic test_zero_size();
    do_request(1'b1, 48'hABCD, 48'd0, -1, "zero_size");
  endtask

  task automatic test_fault();
    do_request(1'b0, 48'h5000, 48'd200000, 1, "fault_2nd");
    do_request(1'b1, 48'h9000, 48'd70000, 0, "fault_1st");
  endtask

  task automatic test_wrap();
    do_request(1'b1, 48'hFFFF_FFFF_0000, 48'h20000, -1, "addr_wrap");
  endtask

  task automatic test_reset_mid();
    int done_cnt;
    rec_addr.delete(); rec_size.delete(); rec_type.delete();
    cmd_idx = 0;
    fault_at = -1;
    stall = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_type = 1'b1; req_address = 48'h1234_5678; req_size = 48'd200000;
    @(negedge clk);
    req_valid = 1'b0;
    for (int cyc = 0; cyc < 20 && rec_addr.size() == 0; cyc++) @(negedge clk);
    n_checks++;
    if (rec_addr.size() != 1) begin
      n_fail++;
      $display("[TB] FAIL reset_mid first_cmd: got %0d commands, expected 1", rec_addr.size());
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if ({stat_busy, cmd_valid, cmd_ready} !== 3'b100) begin
      n_fail++;
      $display("[TB] FAIL reset_mid waiting: busy=%b cmd_valid=%b cmd_ready=%b, expected 1 0 0",
               stat_busy, cmd_valid, cmd_ready);
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({req_ready, req_done, req_fault, cmd_valid, cmd_type, stat_busy} !== 6'b100000 ||
        cmd_address !== 48'd0 || cmd_size !== 48'd0 || stat_chunks !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid async: rdy=%b done=%b flt=%b cv=%b ct=%b busy=%b ca=%h cs=%h ch=%0d, expected 1 0 0 0 0 0 0 0 0",
               req_ready, req_done, req_fault, cmd_valid, cmd_type, stat_busy, cmd_address, cmd_size, stat_chunks);
    end
    done_cnt = 0;
    repeat (2) begin
      @(negedge clk);
      if (req_done === 1'b1) done_cnt++;
    end
    reset = 1'b0;
    stall = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (req_done === 1'b1) done_cnt++;
    end
    n_checks++;
    if (done_cnt != 0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid no_done: saw %0d req_done pulses, expected 0", done_cnt);
    end
    do_request(1'b0, 48'h777, 48'd70000, -1, "after_reset");
  endtask

`ifdef SATA_CMD_SPLITTER_RANGE_CHECK_EN
  task automatic test_range_check();
    info_max_lba_address = 48'hFFFF;
    do_request(1'b0, 48'hFFF0, 48'h20, -1, "range_reject");
    do_request(1'b0, 48'hFFF0, 48'h10, -1, "range_edge_ok");
    info_valid = 1'b0;
    do_request(1'b1, 48'h10, 48'h10, -1, "info_invalid");
    info_valid = 1'b1;
    info_max_lba_address = 48'hFFFF_FFFF_FFFF;
  endtask
`endif

  task automatic test_random();
    logic [47:0] addr, size;
    int f;
    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 3))
        0:       size = 48'($urandom_range(0, 20));
        1:       size = 48'($urandom_range(1, 300000));
        2:       size = 48'(MAX_CHUNK * $urandom_range(1, 4));
        default: size = 48'(MAX_CHUNK * $urandom_range(1, 3) + $urandom_range(0, 2) - 1);
      endcase
      addr = {16'($urandom), 32'($urandom)};
      if ($urandom_range(0, 3) == 0) addr = 48'hFFFF_FFFF_FFFF - 48'($urandom_range(0, 70000));
      f = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 4) : -1;
      do_request(1'($urandom), addr, size, f, $sformatf("random%0d", i));
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_split();
    test_zero_size();
    test_fault();
    test_wrap();
    test_reset_mid();
`ifdef SATA_CMD_SPLITTER_RANGE_CHECK_EN
    test_range_check();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
